jelly2_img_to_axi4s_buffered: RTL



---
 rtl/jelly2_img_to_axi4s_buffered.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/jelly2_img_to_axi4s_buffered.sv
// cke-gated img bus to AXI4-Stream video (SOF on tuser[0], EOL on tlast) through a circular FIFO.
// Latency: 1 cycle from an accepted img pixel to tvalid when the FIFO is empty.
// Backpressure: img side cannot stall; tready stalls fill the FIFO, overflow drops pixels until the next SOF.
module jelly2_img_to_axi4s_buffered #(
    parameter  int TUSER_WIDTH    = 1,
    parameter  int TDATA_WIDTH    = 8,
    parameter  int FIFO_PTR_WIDTH = 5,
    localparam int USER_WIDTH     = (TUSER_WIDTH > 1) ? (TUSER_WIDTH - 1) : 1
) (
    input  logic                      aresetn,
    input  logic                      aclk,
    input  logic                      cke,

    input  logic                      s_img_row_first,
    input  logic                      s_img_row_last,
    input  logic                      s_img_col_first,
    input  logic                      s_img_col_last,
    input  logic                      s_img_de,
    input  logic [USER_WIDTH-1:0]     s_img_user,
    input  logic [TDATA_WIDTH-1:0]    s_img_data,
    input  logic                      s_img_valid,

    output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
    output logic                      m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
    output logic                      m_axi4s_tvalid,
    input  logic                      m_axi4s_tready,

    input  logic                      clear_overflow,
    output logic                      overflow,
    output logic [FIFO_PTR_WIDTH:0]   fifo_count
);

    localparam int                  DEPTH      = 1 << FIFO_PTR_WIDTH;
    localparam logic [FIFO_PTR_WIDTH:0] FULL_COUNT = {1'b1, {FIFO_PTR_WIDTH{1'b0}}};

    typedef struct packed {
        logic [TUSER_WIDTH-1:0] tuser;
        logic                   tlast;
        logic [TDATA_WIDTH-1:0] tdata;
    } entry_t;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    px;
    logic                    sof;
    logic                    full;
    logic                    empty;
    logic                    wr_en;
    logic                    rd_en;
    logic                    ovf_set;
    logic [FIFO_PTR_WIDTH:0] wr_ptr;
    logic [FIFO_PTR_WIDTH:0] rd_ptr;
    logic [FIFO_PTR_WIDTH:0] count;
    entry_t                  mem [DEPTH];
    entry_t                  wr_entry;
    entry_t                  rd_entry;
    logic                    unused_inputs;

    // Row-last carries no information the stream needs; user is unused when TUSER_WIDTH is 1.
    assign unused_inputs = s_img_row_last ^ (^s_img_user);

    assign px    = cke & s_img_valid & s_img_de;
    assign sof   = s_img_row_first & s_img_col_first;
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign rd_en = !empty && m_axi4s_tready;

    generate
        if (TUSER_WIDTH > 1) begin : g_user
            assign wr_entry.tuser = {s_img_user, sof};
        end else begin : g_nouser
            assign wr_entry.tuser = sof;
        end
    endgenerate
    assign wr_entry.tlast = s_img_col_last;
    assign wr_entry.tdata = s_img_data;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a rejected pixel always leaves (or keeps) us in SYNC
    always_comb begin
        state_next = state;
        case (state)
            ST_SYNC: if (px && sof && !full) state_next = ST_RUN;
            ST_RUN:  if (px && full)         state_next = ST_SYNC;
            default:                         state_next = ST_SYNC;
        endcase
    end

    // Output logic: full is judged on the registered count, so a same-cycle read never frees a slot
    always_comb begin
        wr_en   = 1'b0;
        ovf_set = 1'b0;
        if (px && (state == ST_RUN || sof)) begin
            wr_en   = !full;
            ovf_set = full;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_PTR_WIDTH-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign rd_entry       = mem[rd_ptr[FIFO_PTR_WIDTH-1:0]];
    assign m_axi4s_tvalid = !empty;
    assign m_axi4s_tuser  = rd_entry.tuser;
    assign m_axi4s_tlast  = rd_entry.tlast;
    assign m_axi4s_tdata  = rd_entry.tdata;
    assign fifo_count     = count;

endmodule
